// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state encodings and requester ids for the data-memory arbiter
package dmem_arb_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/rr_lock_pick.sv
// rr_lock_pick: 2-way round-robin pick with bounded DMA burst lock; reqs_i[0]=CPU, reqs_i[1]=DMA, winner_o=REQ_* id
module rr_lock_pick
  import dmem_arb_pkg::*;
#(
  parameter int HW       = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic [1:0]    reqs_i,
  input  logic          owner_i,
  input  logic          lock_i,
  input  logic [HW-1:0] hold_cnt_i,
  output logic          winner_o
);
  logic keep_dma;
  assign keep_dma = owner_i == REQ_DMA && lock_i && hold_cnt_i < HW'(MAX_HOLD);
  // a lone requester wins outright; under contention the lock may keep DMA, else alternate
  assign winner_o = reqs_i == 2'b11 ? (keep_dma ? REQ_DMA : ~owner_i) : reqs_i[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for a single-port sync memory; registered mem_* command, gnt pulse in GRANT, rvalid pulse in RESP, rdata_o = mem_rdata_i
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic          dma_lock_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wen_o,
  output logic          mem_ren_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          owner_o
);
  localparam int HW = 4;
  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d, ren_q, ren_d;
  logic          cgnt_q, cgnt_d, dgnt_q, dgnt_d;
  logic          crv_q, crv_d, drv_q, drv_d;
  logic          win;

  rr_lock_pick #(.HW(HW), .MAX_HOLD(MAX_HOLD)) u_pick (
    .reqs_i    ({dma_req_i, cpu_req_i}),
    .owner_i   (owner_q),
    .lock_i    (dma_lock_i),
    .hold_cnt_i(hold_q),
    .winner_o  (win)
  );

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    hold_d  = hold_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    cgnt_d  = 1'b0;
    dgnt_d  = 1'b0;
    crv_d   = 1'b0;
    drv_d   = 1'b0;
    if (state_q == GRANT) begin
      state_d = RESP;
      crv_d   = !we_q && owner_q == REQ_CPU;
      drv_d   = !we_q && owner_q == REQ_DMA;
    end else if (cpu_req_i || dma_req_i) begin
      // IDLE and RESP both sample requests, giving back-to-back accesses every 2 cycles
      state_d = GRANT;
      owner_d = win;
      we_d    = win ? dma_we_i : cpu_we_i;
      addr_d  = win ? dma_addr_i : cpu_addr_i;
      wdata_d = win ? dma_wdata_i : cpu_wdata_i;
      wen_d   = we_d;
      ren_d   = !we_d;
      cgnt_d  = win == REQ_CPU;
      dgnt_d  = win == REQ_DMA;
      hold_d  = (win == REQ_CPU || !dma_lock_i) ? '0 : hold_q == HW'(MAX_HOLD) ? hold_q : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= REQ_DMA;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      cgnt_q  <= 1'b0;
      dgnt_q  <= 1'b0;
      crv_q   <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      cgnt_q  <= cgnt_d;
      dgnt_q  <= dgnt_d;
      crv_q   <= crv_d;
      drv_q   <= drv_d;
    end
  end

  assign cpu_gnt_o    = cgnt_q;
  assign dma_gnt_o    = dgnt_q;
  assign cpu_rvalid_o = crv_q;
  assign dma_rvalid_o = drv_q;
  assign rdata_o      = mem_rdata_i;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wen_o    = wen_q;
  assign mem_ren_o    = ren_q;
  assign owner_o      = owner_q;
endmodule
